// File: rtl/life_sched_pkg.sv
// Shared types and constants for the Game-of-Life generation scheduler.
// Optional build macro used by the top level: LIFE_SCHED_OVERRUN_CNT_EN.
package life_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        START = 2'd2,
        BUSY  = 2'd3
    } sched_state_t;

    // One second at a 12 MHz system clock.
    localparam int unsigned LIFE_DEFAULT_PERIOD = 32'd12_000_000;

    function automatic logic is_busy_state(input sched_state_t s);
        return (s == START) || (s == BUSY);
    endfunction

endpackage

// File: rtl/life_step_scheduler_tick_divider.sv
// Programmable tick divider: counts 0..period-1 while enabled and emits a
// registered one-cycle tick on each wrap. A period load restarts the count.
module tick_divider #(
    parameter int          PERIOD_W       = 24,
    parameter int unsigned DEFAULT_PERIOD = 12_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_en,
    input  logic                period_ld,
    input  logic [PERIOD_W-1:0] period_in,
    output logic                tick
);

    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] count_reg;
    logic                tick_reg;
    logic                wrap;

    // Periods of 0 and 1 both degenerate to a tick on every cycle.
    assign wrap = (period_reg <= PERIOD_W'(1)) ||
                  (count_reg >= (period_reg - PERIOD_W'(1)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            period_reg <= PERIOD_W'(DEFAULT_PERIOD);
            count_reg  <= '0;
            tick_reg   <= 1'b0;
        end else if (period_ld) begin
            period_reg <= period_in;
            count_reg  <= '0;
            tick_reg   <= 1'b0;
        end else if (!run_en) begin
            count_reg  <= '0;
            tick_reg   <= 1'b0;
        end else if (wrap) begin
            count_reg  <= '0;
            tick_reg   <= 1'b1;
        end else begin
            count_reg  <= count_reg + PERIOD_W'(1);
            tick_reg   <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/life_step_scheduler.sv
// Run/pause/single-step scheduler issuing one gen_start per tick to the grid engine.
// Build macro LIFE_SCHED_OVERRUN_CNT_EN adds a saturating dropped-tick counter.
module life_step_scheduler
    import life_sched_pkg::*;
#(
    parameter int          PERIOD_W       = 24,
    parameter int unsigned DEFAULT_PERIOD = LIFE_DEFAULT_PERIOD,
    parameter int          GEN_W          = 16,
    parameter int          OVR_W          = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_en,
    input  logic                step_req,
    input  logic                period_ld,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                gen_done,
    output logic                gen_start,
    output logic                tick,
    output logic                sched_busy,
    output logic [GEN_W-1:0]    gen_count,
    output logic [OVR_W-1:0]    overrun_cnt
);

    sched_state_t     state_reg;
    sched_state_t     state_next;
    logic             gen_start_reg;
    logic             sched_busy_reg;
    logic [GEN_W-1:0] gen_count_reg;
    logic             done_accept;

    tick_divider #(
        .PERIOD_W       (PERIOD_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_tick_divider (
        .clk       (clk),
        .rst       (rst),
        .run_en    (run_en),
        .period_ld (period_ld),
        .period_in (period_in),
        .tick      (tick)
    );

    // A single-step request takes priority over entering free-run.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (step_req)
                    state_next = START;
                else if (run_en)
                    state_next = WAIT;
            end
            WAIT: begin
                if (!run_en)
                    state_next = IDLE;
                else if (tick)
                    state_next = START;
            end
            START: state_next = BUSY;
            BUSY: begin
                if (gen_done)
                    state_next = run_en ? WAIT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign done_accept = (state_reg == BUSY) && gen_done;

    // Outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            gen_start_reg  <= 1'b0;
            sched_busy_reg <= 1'b0;
            gen_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            gen_start_reg  <= (state_next == START);
            sched_busy_reg <= is_busy_state(state_next);
            if (done_accept)
                gen_count_reg <= gen_count_reg + GEN_W'(1);
        end
    end

    assign gen_start  = gen_start_reg;
    assign sched_busy = sched_busy_reg;
    assign gen_count  = gen_count_reg;

`ifdef LIFE_SCHED_OVERRUN_CNT_EN
    logic             overrun_evt;
    logic [OVR_W-1:0] overrun_cnt_reg;

    // Ticks landing while a generation is in flight are dropped, never queued.
    assign overrun_evt = tick && is_busy_state(state_reg);

    always_ff @(posedge clk) begin
        if (!rst)
            overrun_cnt_reg <= '0;
        else if (overrun_evt && (overrun_cnt_reg != {OVR_W{1'b1}}))
            overrun_cnt_reg <= overrun_cnt_reg + OVR_W'(1);
    end

    assign overrun_cnt = overrun_cnt_reg;
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_life_step_scheduler.sv
// Directed bench for life_step_scheduler with a small latency-programmable engine model.
// Expected overrun values follow LIFE_SCHED_OVERRUN_CNT_EN.
module tb_life_step_scheduler;

    localparam int PERIOD_W = 24;
    localparam int GEN_W    = 16;
    localparam int OVR_W    = 8;

`ifdef LIFE_SCHED_OVERRUN_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                run_en = 1'b0;
    logic                step_req = 1'b0;
    logic                period_ld = 1'b0;
    logic [PERIOD_W-1:0] period_in = '0;
    logic                gen_done = 1'b0;
    logic                gen_start;
    logic                tick;
    logic                sched_busy;
    logic [GEN_W-1:0]    gen_count;
    logic [OVR_W-1:0]    overrun_cnt;

    int checks = 0;
    int errors = 0;

    int engine_lat = 0;
    int eng_cnt    = 0;
    bit eng_active = 1'b0;

    always #5 clk = ~clk;

    life_step_scheduler #(
        .PERIOD_W       (PERIOD_W),
        .DEFAULT_PERIOD (4),
        .GEN_W          (GEN_W),
        .OVR_W          (OVR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .step_req    (step_req),
        .period_ld   (period_ld),
        .period_in   (period_in),
        .gen_done    (gen_done),
        .gen_start   (gen_start),
        .tick        (tick),
        .sched_busy  (sched_busy),
        .gen_count   (gen_count),
        .overrun_cnt (overrun_cnt)
    );

    // One clock: outputs are settled on return, pulses are cleared, engine model advances.
    task automatic cyc();
        @(posedge clk);
        #1;
        step_req  = 1'b0;
        period_ld = 1'b0;
        gen_done  = 1'b0;
        if (engine_lat > 0) begin
            if (gen_start) begin
                eng_active = 1'b1;
                eng_cnt    = 0;
            end else if (eng_active) begin
                eng_cnt++;
                if (eng_cnt == engine_lat) begin
                    gen_done   = 1'b1;
                    eng_active = 1'b0;
                    if (gen_count < 4)
                        $display("  engine: gen_done at %0t (gen_count before=%0d)", $time, gen_count);
                end
            end
        end
    endtask

    task automatic do_reset(input bit run);
        rst        = 1'b0;
        run_en     = run;
        engine_lat = 0;
        eng_active = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic run_until_gen(input int target, input int bound,
                                 output int starts, output bit reached);
        starts  = 0;
        reached = 1'b0;
        for (int k = 0; k < bound; k++) begin
            cyc();
            if (gen_start) starts++;
            if (gen_count == GEN_W'(target)) begin
                reached = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int first_tick;
        rst    = 1'b0;
        run_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({gen_start, tick, sched_busy, gen_count, overrun_cnt} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b, expected 0",
                         i, {gen_start, tick, sched_busy, gen_count, overrun_cnt});
            end
        end
        rst = 1'b1;
        first_tick = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (tick) begin
                first_tick = k;
                break;
            end
        end
        checks++;
        if (first_tick != 4) begin
            errors++;
            $display("FAIL reset_first_tick: got cycle %0d, expected 4", first_tick);
        end
        $display("test_reset: first tick at cycle %0d after release", first_tick);
    endtask

    task automatic test_free_run();
        int last_tick, prev_start, n_starts;
        do_reset(1'b1);
        engine_lat = 2;
        last_tick  = -10;
        prev_start = 0;
        n_starts   = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (gen_start) begin
                $display("test_free_run: gen_start at cycle %0d", k);
                checks++;
                if (last_tick != k - 1) begin
                    errors++;
                    $display("FAIL free_run_latency: start at %0d, last tick %0d, expected tick at %0d",
                             k, last_tick, k - 1);
                end
                if (prev_start > 0) begin
                    checks++;
                    if (k - prev_start != 4) begin
                        errors++;
                        $display("FAIL free_run_spacing: got %0d cycles, expected 4", k - prev_start);
                    end
                end
                prev_start = k;
                n_starts++;
            end
            if (tick) last_tick = k;
            if (gen_count == 3) break;
        end
        checks++;
        if (gen_count !== 16'd3) begin
            errors++;
            $display("FAIL free_run_count: got %0d, expected 3", gen_count);
        end
        checks++;
        if (n_starts != 3) begin
            errors++;
            $display("FAIL free_run_starts: got %0d, expected 3", n_starts);
        end
    endtask

    task automatic test_single_step();
        int extra;
        do_reset(1'b0);
        engine_lat = 2;
        cyc();
        cyc();
        checks++;
        if ({sched_busy, gen_start, tick} !== 3'b000) begin
            errors++;
            $display("FAIL step_idle: got busy/start/tick %b, expected 000", {sched_busy, gen_start, tick});
        end
        step_req = 1'b1;
        cyc();
        checks++;
        if (gen_start !== 1'b1) begin
            errors++;
            $display("FAIL step_start: got %b, expected 1", gen_start);
        end
        cyc();
        checks++;
        if ({sched_busy, gen_start} !== 2'b10) begin
            errors++;
            $display("FAIL step_busy: got busy/start %b, expected 10", {sched_busy, gen_start});
        end
        step_req = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (gen_start) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL step_no_extra_start: got %0d starts, expected 0", extra);
        end
        checks++;
        if ({gen_count, sched_busy} !== {16'd1, 1'b0}) begin
            errors++;
            $display("FAIL step_done: got count %0d busy %b, expected count 1 busy 0", gen_count, sched_busy);
        end
        $display("test_single_step: gen_count=%0d", gen_count);
    endtask

    task automatic test_overrun();
        int starts, total_starts;
        bit reached;
        logic [OVR_W-1:0] exp_ovr;
        do_reset(1'b1);
        engine_lat = 10;
        run_until_gen(1, 60, starts, reached);
        total_starts = starts;
        exp_ovr = OVR_EN ? 8'd2 : 8'd0;
        checks++;
        if (!reached || overrun_cnt !== exp_ovr) begin
            errors++;
            $display("FAIL overrun_first_gen: reached %b, got %0d, expected %0d", reached, overrun_cnt, exp_ovr);
        end
        run_until_gen(127, 3000, starts, reached);
        total_starts += starts;
        exp_ovr = OVR_EN ? 8'd254 : 8'd0;
        checks++;
        if (!reached || overrun_cnt !== exp_ovr) begin
            errors++;
            $display("FAIL overrun_gen127: reached %b, got %0d, expected %0d", reached, overrun_cnt, exp_ovr);
        end
        run_until_gen(130, 200, starts, reached);
        total_starts += starts;
        exp_ovr = OVR_EN ? 8'd255 : 8'd0;
        checks++;
        if (!reached || overrun_cnt !== exp_ovr) begin
            errors++;
            $display("FAIL overrun_saturate: reached %b, got %0d, expected %0d", reached, overrun_cnt, exp_ovr);
        end
        checks++;
        if (total_starts != 130) begin
            errors++;
            $display("FAIL overrun_not_queued: got %0d starts, expected 130", total_starts);
        end
        $display("test_overrun: 130 generations, overrun_cnt=%0d", overrun_cnt);
    endtask

    task automatic test_period_ld();
        int starts;
        bit reached;
        logic [OVR_W-1:0] exp_ovr;
        do_reset(1'b1);
        cyc();
        cyc();
        period_in = 24'd2;
        period_ld = 1'b1;
        cyc();
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL load2_tick: got %b, expected 0", tick);
        end
        for (int j = 1; j <= 5; j++) begin
            cyc();
            checks++;
            if (tick !== ((j % 2) == 0)) begin
                errors++;
                $display("FAIL load2_pattern j=%0d: got %b, expected %b", j, tick, (j % 2) == 0);
            end
        end
        period_in = 24'd0;
        period_ld = 1'b1;
        cyc();
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL load_wins_over_wrap: got %b, expected 0", tick);
        end
        for (int j = 0; j < 4; j++) begin
            cyc();
            checks++;
            if (tick !== 1'b1) begin
                errors++;
                $display("FAIL load0_every_cycle j=%0d: got %b, expected 1", j, tick);
            end
        end
        $display("test_period_ld: divider reload sequence done");

        do_reset(1'b0);
        period_in = 24'd0;
        period_ld = 1'b1;
        cyc();
        engine_lat = 2;
        run_en     = 1'b1;
        run_until_gen(1, 20, starts, reached);
        checks++;
        if (!reached || {sched_busy, tick} !== 2'b01) begin
            errors++;
            $display("FAIL done_with_tick_wait: reached %b, got busy/tick %b, expected 01", reached, {sched_busy, tick});
        end
        cyc();
        checks++;
        if (gen_start !== 1'b1) begin
            errors++;
            $display("FAIL done_with_tick_restart: got %b, expected 1", gen_start);
        end
        run_until_gen(2, 20, starts, reached);
        exp_ovr = OVR_EN ? 8'd6 : 8'd0;
        checks++;
        if (!reached || overrun_cnt !== exp_ovr) begin
            errors++;
            $display("FAIL done_with_tick_overrun: reached %b, got %0d, expected %0d", reached, overrun_cnt, exp_ovr);
        end
        $display("test_period_ld: coincident done/tick, overrun_cnt=%0d", overrun_cnt);
    endtask

    task automatic test_mid_reset();
        int extra;
        do_reset(1'b0);
        step_req = 1'b1;
        cyc();
        cyc();
        checks++;
        if (sched_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy: got %b, expected 1", sched_busy);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if ({sched_busy, gen_start} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_abandon: got busy/start %b, expected 00", {sched_busy, gen_start});
        end
        rst = 1'b1;
        cyc();
        gen_done = 1'b1;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (gen_start || sched_busy) extra++;
        end
        checks++;
        if (gen_count !== 16'd0) begin
            errors++;
            $display("FAIL midrst_stray_done: got count %0d, expected 0", gen_count);
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL midrst_stays_idle: got %0d active cycles, expected 0", extra);
        end
        $display("test_mid_reset: gen_count=%0d after stray gen_done", gen_count);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_single_step();
        test_overrun();
        test_period_ld();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
